// File: rtl/seg_scan_driver_if.sv
// Signal bundle between the display-value source and the 7-segment scan driver.
// The source drives value/digit_en/dp_in; the scanner drives anodes, code, dp_n and frame_done.
interface seg_scan_driver_if;
    logic [31:0] value;
    logic [7:0]  digit_en;
    logic [7:0]  dp_in;
    logic [7:0]  an;
    logic [3:0]  code;
    logic        dp_n;
    logic        frame_done;

    modport master (
        output value, digit_en, dp_in,
        input  an, code, dp_n, frame_done
    );

    modport slave (
        input  value, digit_en, dp_in,
        output an, code, dp_n, frame_done
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scanner for an 8-digit common-anode 7-segment display.
// Inputs are captured once per frame into shadow registers so a digit never tears mid-scan.
module seg_scan_driver #(
    parameter int DIV_CYCLES = 100000,
    parameter int GUARD      = 2
) (
    input logic             clk,
    input logic             rst,
    seg_scan_driver_if.slave bus
);

    localparam int              CNT_W    = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic             load_pending;
    logic [31:0]      val_s;
    logic [7:0]       en_s;
    logic [7:0]       dp_s;

    logic             tick;
    logic             frame_end;
    logic             load;
    logic             in_guard;

    assign tick      = (cnt == CNT_LAST);
    assign frame_end = tick && (idx == 3'd7);
    assign load      = load_pending || frame_end;

    // With no guard band the blanking compare would be constant, so it is dropped entirely.
    generate
        if (GUARD == 0) begin : g_no_guard
            assign in_guard = 1'b0;
        end else begin : g_guard
            localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);
            assign in_guard = (cnt < GUARD_C);
        end
    endgenerate

    function automatic logic [7:0] anode_sel(input logic [2:0] i, input logic lit);
        logic [7:0] r;
        r = 8'hFF;
        if (lit) begin
            r = ~(8'h01 << i);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            idx            <= 3'd0;
            load_pending   <= 1'b1;
            val_s          <= 32'h0;
            en_s           <= 8'h00;
            dp_s           <= 8'h00;
            bus.an         <= 8'hFF;
            bus.code       <= 4'h0;
            bus.dp_n       <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            // Slot timing: prescaler and digit index
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= idx + 3'd1;
            end

            // Frame-boundary capture; the new contents take effect from digit 0
            load_pending <= 1'b0;
            if (load) begin
                val_s <= bus.value;
                en_s  <= bus.digit_en;
                dp_s  <= bus.dp_in;
            end

            // Output stage: one cycle behind the current slot position
            bus.code       <= val_s[{idx, 2'b00} +: 4];
            bus.dp_n       <= ~dp_s[idx];
            bus.an         <= anode_sel(idx, !in_guard && en_s[idx]);
            bus.frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (guard 1 and guard 0) share stimulus; a positional
// reference model queues the expected outputs per cycle and a negedge monitor compares them.
module tb_seg_scan_driver;

    localparam int DIV     = 4;
    localparam int FRAME   = 8 * DIV;
    localparam int GUARD_A = 1;
    localparam int GUARD_B = 0;

    typedef struct packed {
        logic [7:0] an;
        logic [3:0] code;
        logic       dp_n;
        logic       fd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] value_drv;
    logic [7:0]  en_drv;
    logic [7:0]  dp_drv;

    int tests;
    int fails;
    int n;
    bit started;

    logic [31:0] sh_v;
    logic [7:0]  sh_e;
    logic [7:0]  sh_d;

    exp_t q_a[$];
    exp_t q_b[$];

    seg_scan_driver_if bus_a ();
    seg_scan_driver_if bus_b ();

    assign bus_a.value    = value_drv;
    assign bus_a.digit_en = en_drv;
    assign bus_a.dp_in    = dp_drv;
    assign bus_b.value    = value_drv;
    assign bus_b.digit_en = en_drv;
    assign bus_b.dp_in    = dp_drv;

    seg_scan_driver #(.DIV_CYCLES(DIV), .GUARD(GUARD_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    seg_scan_driver #(.DIV_CYCLES(DIV), .GUARD(GUARD_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after the n-th edge since reset release, from the slot position alone.
    function automatic exp_t model(input int k, input int guard, input logic [31:0] v,
                                   input logic [7:0] e, input logic [7:0] d);
        exp_t r;
        int   p;
        int   slot;
        int   off;
        p      = k - 1;
        slot   = (p / DIV) % 8;
        off    = p % DIV;
        r.code = v[slot*4 +: 4];
        r.dp_n = ~d[slot];
        r.an   = ((off < guard) || !e[slot]) ? 8'hFF : ~(8'h01 << slot);
        r.fd   = ((k % FRAME) == 0);
        return r;
    endfunction

    function automatic exp_t reset_exp();
        exp_t r;
        r.an   = 8'hFF;
        r.code = 4'h0;
        r.dp_n = 1'b1;
        r.fd   = 1'b0;
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            started = 1'b1;
            n       = 0;
            sh_v    = 32'h0;
            sh_e    = 8'h00;
            sh_d    = 8'h00;
            q_a.push_back(reset_exp());
            q_b.push_back(reset_exp());
        end else if (started) begin
            n = n + 1;
            q_a.push_back(model(n, GUARD_A, sh_v, sh_e, sh_d));
            q_b.push_back(model(n, GUARD_B, sh_v, sh_e, sh_d));
            if (n == 1 || (n % FRAME) == 0) begin
                sh_v = value_drv;
                sh_e = en_drv;
                sh_d = dp_drv;
            end
        end
    end

    task automatic check(input string name, input exp_t exp, input logic [7:0] an,
                         input logic [3:0] code, input logic dp_n, input logic fd);
        exp_t act;
        act.an   = an;
        act.code = code;
        act.dp_n = dp_n;
        act.fd   = fd;
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s step=%0d got an=%h code=%h dp_n=%b fd=%b, want an=%h code=%h dp_n=%b fd=%b",
                     name, n, act.an, act.code, act.dp_n, act.fd, exp.an, exp.code, exp.dp_n, exp.fd);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check("guard1", e, bus_a.an, bus_a.code, bus_a.dp_n, bus_a.frame_done);
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check("guard0", e, bus_b.an, bus_b.code, bus_b.dp_n, bus_b.frame_done);
        end
    end

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance until the last edge left the scan at the given frame position (bounded).
    task automatic wait_pos(input int target);
        int guard_cnt;
        guard_cnt = 0;
        while ((n % FRAME) != target && guard_cnt < 2 * FRAME) begin
            cyc(1);
            guard_cnt = guard_cnt + 1;
        end
        tests = tests + 1;
        if ((n % FRAME) != target) begin
            fails = fails + 1;
            $display("FAIL wait_pos got=%0d want=%0d", n % FRAME, target);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        n         = 0;
        started   = 1'b0;
        rst       = 1'b1;
        value_drv = 32'h89ABCDEF;
        en_drv    = 8'hFF;
        dp_drv    = 8'h00;
        cyc(3);
        rst = 1'b0;
        cyc(70);

        // Mid-frame change while digit 3 is shown; must wait for the frame boundary
        wait_pos(13);
        value_drv = 32'h12345678;
        cyc(70);

        en_drv = 8'b0000_0101;
        dp_drv = 8'h04;
        cyc(70);

        // One-cycle reset in the middle of digit 5, with new inputs to be re-latched
        en_drv = 8'hFF;
        wait_pos(21);
        rst       = 1'b1;
        value_drv = 32'hCAFEF00D;
        dp_drv    = 8'hA5;
        cyc(1);
        rst = 1'b0;
        cyc(70);

        // Inputs changed so they are present exactly on the frame-boundary tick
        wait_pos(31);
        value_drv = 32'h0F1E2D3C;
        en_drv    = 8'h7E;
        dp_drv    = 8'h81;
        cyc(40);

        for (int i = 0; i < 40; i++) begin
            value_drv = $urandom;
            en_drv    = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            dp_drv    = 8'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                cyc(1);
                rst = 1'b0;
            end
            cyc($urandom_range(1, 30));
        end

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        fails = fails + 1;
        $display("FAIL watchdog time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
